// File: rtl/ann_frame_loader.sv
// Serial sample loader for the ann stage: builds a 6-sample vector, holds it, captures fop.
// Optional frame-end checking via s_last/frame_err when ANN_LOADER_LAST_CHECK_EN is defined.
module ann_frame_loader #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [2:0]       s_data,
`ifdef ANN_LOADER_LAST_CHECK_EN
    input  logic             s_last,
    output logic             frame_err,
`endif
    output logic [2:0]       a1,
    output logic [2:0]       a2,
    output logic [2:0]       a3,
    output logic [2:0]       a4,
    output logic [2:0]       a5,
    output logic [2:0]       a6,
    input  logic [7:0]       fop_in,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [7:0]       r_data,
    output logic [CNT_W-1:0] r_tag
);

    localparam logic [1:0] FILL   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] OUT    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [2:0]       a_q [6];
    logic [2:0]       a_d [6];
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] frame_q, frame_d;
    logic             ready_q, ready_d;
    logic             rvalid_q, rvalid_d;
    logic [7:0]       rdata_q, rdata_d;
    logic [CNT_W-1:0] rtag_q, rtag_d;
    logic             early;
`ifdef ANN_LOADER_LAST_CHECK_EN
    logic             err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        frame_d  = frame_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rtag_d   = rtag_q;
        early    = 1'b0;
`ifdef ANN_LOADER_LAST_CHECK_EN
        err_d    = err_q;
        early    = s_last && (idx_q != 3'd5);
`endif
        case (state_q)
            FILL: begin
                if (s_valid && ready_q) begin
                    for (int i = 0; i < 6; i++) begin
                        if (idx_q == 3'(i)) a_d[i] = s_data;
                    end
`ifdef ANN_LOADER_LAST_CHECK_EN
                    if (early || (idx_q == 3'd5 && !s_last)) err_d = 1'b1;
`endif
                    if (early) begin
                        idx_d = 3'd0;
                    end else if (idx_q == 3'd5) begin
                        idx_d   = 3'd0;
                        cnt_d   = 4'(SETTLE_CYCLES);
                        state_d = SETTLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            SETTLE: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    rdata_d  = fop_in;
                    rtag_d   = frame_q;
                    frame_d  = frame_q + 1'b1;
                    rvalid_d = 1'b1;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (r_ready) begin
                    rvalid_d = 1'b0;
                    state_d  = FILL;
                end
            end
            default: state_d = FILL;
        endcase
        // ready is registered so it never follows s_valid/r_ready combinationally
        ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            a_q      <= '{default: 3'd0};
            idx_q    <= 3'd0;
            cnt_q    <= 4'd0;
            frame_q  <= '0;
            ready_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 8'd0;
            rtag_q   <= '0;
`ifdef ANN_LOADER_LAST_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            frame_q  <= frame_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rtag_q   <= rtag_d;
`ifdef ANN_LOADER_LAST_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    assign s_ready = ready_q;
    assign a1      = a_q[0];
    assign a2      = a_q[1];
    assign a3      = a_q[2];
    assign a4      = a_q[3];
    assign a5      = a_q[4];
    assign a6      = a_q[5];
    assign r_valid = rvalid_q;
    assign r_data  = rdata_q;
    assign r_tag   = rtag_q;
`ifdef ANN_LOADER_LAST_CHECK_EN
    assign frame_err = err_q;
`endif

endmodule
